alu_arbiter: RTL and testbench

Shares one combinational `alu` instance between N_REQ requesters, e.g. the integer execute path and a CSR/address helper unit. Each requester has a valid/ready request channel and a valid/ready response channel. A round-robin grant picks at most one requester per cycle and drives the ALU with its operands and opcode. The ALU result is captured into a 1-deep per-requester response buffer, so results appear one cycle after acceptance.

---
 rtl/alu_arbiter.sv | 95 +++++++++
 tb/tb_alu_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between N_REQ requesters,
// with a 1-deep response buffer per requester (1-cycle result latency).
module alu_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_op,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     resp_valid,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic [32*N_REQ-1:0]  resp_data,
    output logic [31:0]          alu_operand_a,
    output logic [31:0]          alu_operand_b,
    output logic [3:0]           alu_op_o,
    input  logic [31:0]          alu_data_i
);

    logic [N_REQ-1:0]    r_resp_valid;
    logic [32*N_REQ-1:0] r_resp_data;
    logic [PTR_W-1:0]    r_rr_ptr;

    logic [N_REQ-1:0]    w_eligible;
    logic [N_REQ-1:0]    w_grant;
    logic [N_REQ-1:0]    w_accept;
    logic [PTR_W-1:0]    w_win;
    logic                w_found;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int k);
        wrap_idx = PTR_W'((int'(p) + k) % N_REQ);
    endfunction

    // A full buffer is still eligible when it is being drained this same cycle.
    assign w_eligible = req_valid & (~r_resp_valid | resp_ready);

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && w_eligible[wrap_idx(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_win] = 1'b1;
        end
    end

    assign req_ready = i_reset ? '0 : w_grant;
    assign w_accept  = req_ready & req_valid;

    always_comb begin
        alu_operand_a = 32'h0;
        alu_operand_b = 32'h0;
        alu_op_o      = 4'h0;
        if (w_found) begin
            alu_operand_a = req_a[32*int'(w_win) +: 32];
            alu_operand_b = req_b[32*int'(w_win) +: 32];
            alu_op_o      = req_op[4*int'(w_win) +: 4];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_rr_ptr     <= PTR_W'(N_REQ - 1);
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept[i]) begin
                    r_resp_valid[i]           <= 1'b1;
                    r_resp_data[32*i +: 32]   <= alu_data_i;
                end else if (resp_ready[i]) begin
                    r_resp_valid[i]           <= 1'b0;
                end
            end
            if (|w_accept) begin
                r_rr_ptr <= w_win;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (N_REQ=2) with a behavioural ALU model.
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [7:0]  req_op = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = '0;
    logic [63:0] resp_data;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_op;

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter #(.N_REQ(2)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .alu_operand_a(alu_a),
        .alu_operand_b(alu_b),
        .alu_op_o     (alu_op),
        .alu_data_i   (alu_y)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_y = 32'h0;
        case (alu_op)
            OP_ADD:  alu_y = alu_a + alu_b;
            OP_SUB:  alu_y = alu_a - alu_b;
            OP_SLL:  alu_y = alu_a << alu_b[4:0];
            OP_SLTU: alu_y = {31'b0, alu_a < alu_b};
            OP_XOR:  alu_y = alu_a ^ alu_b;
            default: alu_y = 32'h0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]       = v;
        req_op[4*i +: 4]   = op;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_err++; $display("FAIL reset_ready_during: got %b want 00", req_ready);
        end
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (resp_valid !== 2'b00) begin
            n_err++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid);
        end
        n_cmp++;
        if (resp_data !== 64'h0) begin
            n_err++; $display("FAIL reset_resp_data: got %h want 0", resp_data);
        end
        n_cmp++;
        if ({alu_op, alu_a, alu_b} !== 68'h0) begin
            n_err++; $display("FAIL idle_alu_drive: got op=%h a=%h b=%h want 0", alu_op, alu_a, alu_b);
        end
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_err++; $display("FAIL idle_req_ready: got %b want 00", req_ready);
        end
    endtask

    task automatic test_single_add();
        int results = 0;
        tick();
        set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
        resp_ready = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== 2'b01 || alu_a !== 32'd5 || alu_op !== OP_ADD) begin
                n_err++; $display("FAIL add_grant[%0d]: got ready=%b a=%h op=%h want 01 5 0",
                                  k, req_ready, alu_a, alu_op);
            end
            tick();
            n_cmp++;
            if (resp_valid[0] !== 1'b1 || resp_data[31:0] !== 32'd12) begin
                n_err++; $display("FAIL add_resp[%0d]: got v=%b d=%h want 1 0000000c",
                                  k, resp_valid[0], resp_data[31:0]);
            end
            if (resp_valid[0] === 1'b1) results++;
        end
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        tick();
        n_cmp++;
        if (results != 4 || resp_valid[0] !== 1'b0) begin
            n_err++; $display("FAIL add_count: got results=%0d v=%b want 4 0", results, resp_valid[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] want [4];
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
        apply_reset();
        tick();
        set_req(0, 1'b1, OP_SUB, 32'd10, 32'd3);
        set_req(1, 1'b1, OP_SLTU, 32'd1, 32'hFFFF_FFFF);
        resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== want[k]) begin
                n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, want[k]);
            end
            tick();
        end
        n_cmp++;
        if (resp_data[31:0] !== 32'd7 || resp_data[63:32] !== 32'd1) begin
            n_err++; $display("FAIL rr_data: got %h want 00000001_00000007", resp_data);
        end
    endtask

    task automatic test_backpressure();
        req_valid = 2'b00;
        resp_ready = 2'b11;
        tick();
        set_req(0, 1'b1, OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        set_req(1, 1'b1, OP_ADD, 32'd1, 32'd2);
        resp_ready = 2'b10;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL bp_first_grant: got %b want 01", req_ready);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== 2'b10) begin
                n_err++; $display("FAIL bp_grant[%0d]: got %b want 10", k, req_ready);
            end
            tick();
            n_cmp++;
            if (resp_valid !== 2'b11 || resp_data !== {32'd3, 32'hFF00_FF00}) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want 11 00000003ff00ff00",
                                  k, resp_valid, resp_data);
            end
        end
        req_valid = 2'b00;
        resp_ready = 2'b01;
        tick();
        n_cmp++;
        if (resp_valid[0] !== 1'b0 || resp_data[31:0] !== 32'hFF00_FF00) begin
            n_err++; $display("FAIL bp_drain: got v=%b d=%h want 0 ff00ff00",
                              resp_valid[0], resp_data[31:0]);
        end
    endtask

    task automatic test_drain_refill();
        resp_ready = 2'b11;
        req_valid = 2'b00;
        tick();
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
        resp_ready = 2'b00;
        tick();
        n_cmp++;
        if (resp_valid[0] !== 1'b1 || resp_data[31:0] !== 32'd2) begin
            n_err++; $display("FAIL dr_load: got v=%b d=%h want 1 2", resp_valid[0], resp_data[31:0]);
        end
        set_req(0, 1'b1, OP_SLL, 32'd1, 32'd4);
        resp_ready = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL dr_grant: got %b want 01", req_ready);
        end
        tick();
        n_cmp++;
        if (resp_valid[0] !== 1'b1 || resp_data[31:0] !== 32'd16) begin
            n_err++; $display("FAIL dr_refill: got v=%b d=%h want 1 10", resp_valid[0], resp_data[31:0]);
        end
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_async_reset();
        set_req(0, 1'b1, OP_ADD, 32'd4, 32'd4);
        set_req(1, 1'b1, OP_ADD, 32'd9, 32'd9);
        resp_ready = 2'b00;
        tick();
        tick();
        n_cmp++;
        if (resp_valid !== 2'b11 || resp_data !== {32'd18, 32'd8}) begin
            n_err++; $display("FAIL ar_fill: got v=%b d=%h want 11 0000001200000008", resp_valid, resp_data);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (resp_valid !== 2'b00 || resp_data !== 64'h0 || req_ready !== 2'b00) begin
            n_err++; $display("FAIL ar_async: got v=%b d=%h r=%b want 00 0 00", resp_valid, resp_data, req_ready);
        end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01 || alu_a !== 32'd4) begin
            n_err++; $display("FAIL ar_first_grant: got %b a=%h want 01 4", req_ready, alu_a);
        end
        tick();
        n_cmp++;
        if (resp_valid !== 2'b01 || resp_data[31:0] !== 32'd8) begin
            n_err++; $display("FAIL ar_after: got v=%b d=%h want 01 8", resp_valid, resp_data[31:0]);
        end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_drain_refill();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
